// File: rtl/axil_pkg.sv
// axil_pkg: shared types and constants for the AXI4-Lite write slave.
//   state_t      - write-path FSM states (IDLE, WRITE, RESP)
//   RESP_OKAY    - BRESP for a write that hit a register in the window
//   RESP_SLVERR  - BRESP for a write outside the window or misaligned
//   *_WIDTH      - address, data and byte-strobe widths of the bus
package axil_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/axil_addr_check.sv
// axil_addr_check: combinational register-window decode.
//   addr  (in)  - byte address of the write
//   valid (out) - high when addr hits one register of the window
//                 [OFFSET, OFFSET + NUM_ADDRESSES*ADDRESS_STEP) on an
//                 ADDRESS_STEP boundary relative to OFFSET.
module axil_addr_check
  import axil_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] OFFSET        = '0,
  parameter int unsigned           ADDRESS_STEP  = 4,
  parameter int unsigned           NUM_ADDRESSES = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  valid
);

  // One extra bit so a window that ends exactly at 2^32 does not wrap to 0.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, OFFSET};
  localparam logic [ADDR_WIDTH:0] WIN_HI =
    WIN_LO + (33'(NUM_ADDRESSES) * 33'(ADDRESS_STEP));

  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH-1:0] rel_addr;

  assign addr_ext = {1'b0, addr};
  assign rel_addr = addr - OFFSET;

  assign valid = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI) &&
                 ((rel_addr % ADDRESS_STEP) == '0);

endmodule

// File: rtl/axil_write_slave.sv
// axil_write_slave: AXI4-Lite write-only slave that turns one AW+W pair
// into a single-cycle write strobe for a downstream register decoder.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   s_awaddr/s_awvalid/s_awready    - write-address channel
//   s_wdata/s_wstrb/s_wvalid/s_wready - write-data channel
//   s_bresp/s_bvalid/s_bready       - write-response channel
//   wr_address/wr_data/wr_strb      - last captured write (held between writes)
//   write_en                        - one-cycle strobe, only for valid addresses
module axil_write_slave
  import axil_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] OFFSET        = '0,
  parameter int unsigned           ADDRESS_STEP  = 4,
  parameter int unsigned           NUM_ADDRESSES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  write_en
);

  state_t                state_reg;
  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic                  addr_ok_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [ADDR_WIDTH-1:0] wr_address_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [STRB_WIDTH-1:0] wr_strb_reg;
  logic                  write_en_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_have;
  logic                  w_have;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [STRB_WIDTH-1:0] cap_strb;
  logic                  cap_addr_ok;

  // Readies are only ever high in IDLE, so a handshake implies IDLE.
  assign aw_hs   = s_awvalid && awready_reg;
  assign w_hs    = s_wvalid && wready_reg;
  assign aw_have = aw_held_reg || aw_hs;
  assign w_have  = w_held_reg || w_hs;

  // The beat completing the pair may arrive this cycle, so take it from
  // the bus; the earlier beat comes from its holding register.
  assign cap_addr = aw_held_reg ? awaddr_reg : s_awaddr;
  assign cap_data = w_held_reg  ? wdata_reg  : s_wdata;
  assign cap_strb = w_held_reg  ? wstrb_reg  : s_wstrb;

  axil_addr_check #(
    .OFFSET        (OFFSET),
    .ADDRESS_STEP  (ADDRESS_STEP),
    .NUM_ADDRESSES (NUM_ADDRESSES)
  ) u_addr_check (
    .addr  (cap_addr),
    .valid (cap_addr_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      aw_held_reg    <= 1'b0;
      w_held_reg     <= 1'b0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      addr_ok_reg    <= 1'b0;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      wr_address_reg <= '0;
      wr_data_reg    <= '0;
      wr_strb_reg    <= '0;
      write_en_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (aw_hs) begin
            aw_held_reg <= 1'b1;
            awaddr_reg  <= s_awaddr;
            awready_reg <= 1'b0;
          end else if (!aw_held_reg) begin
            awready_reg <= 1'b1;
          end

          if (w_hs) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= s_wdata;
            wstrb_reg  <= s_wstrb;
            wready_reg <= 1'b0;
          end else if (!w_held_reg) begin
            wready_reg <= 1'b1;
          end

          // Pair complete: present it during the next cycle (WRITE).
          if (aw_have && w_have) begin
            state_reg      <= WRITE;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            wr_address_reg <= cap_addr;
            wr_data_reg    <= cap_data;
            wr_strb_reg    <= cap_strb;
            write_en_reg   <= cap_addr_ok;
            addr_ok_reg    <= cap_addr_ok;
          end
        end

        WRITE: begin
          state_reg    <= RESP;
          write_en_reg <= 1'b0;
          bvalid_reg   <= 1'b1;
          bresp_reg    <= addr_ok_reg ? RESP_OKAY : RESP_SLVERR;
        end

        RESP: begin
          // Re-arm both readies on the B handshake so the next pair can be
          // captured on the very next edge.
          if (s_bready) begin
            state_reg   <= IDLE;
            bvalid_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign s_awready  = awready_reg;
  assign s_wready   = wready_reg;
  assign s_bvalid   = bvalid_reg;
  assign s_bresp    = bresp_reg;
  assign wr_address = wr_address_reg;
  assign wr_data    = wr_data_reg;
  assign wr_strb    = wr_strb_reg;
  assign write_en   = write_en_reg;

endmodule

// File: tb/tb_axil_write_slave.sv
// tb_axil_write_slave: table-driven and randomized checks of axil_write_slave
// against a transaction-level model of the register window.
module tb_axil_write_slave;

  localparam logic [31:0] P_OFFSET = 32'h0;
  localparam int unsigned P_STEP   = 4;
  localparam int unsigned P_NUM    = 32;
  localparam int          MAXC     = 200;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        write_en;

  axil_write_slave #(
    .OFFSET        (P_OFFSET),
    .ADDRESS_STEP  (P_STEP),
    .NUM_ADDRESSES (P_NUM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_awaddr   (s_awaddr),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_bresp    (s_bresp),
    .s_bvalid   (s_bvalid),
    .s_bready   (s_bready),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .write_en   (write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    bit          exp_we;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    int          we_count;
    int          we_cycle;
    int          hs_cycle;
    int          bv_cycle;
    int          stall;
    int          viol;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    logic [3:0]  we_strb;
    logic [1:0]  resp;
    bit          timeout;
  } res_t;

  int total = 0;
  int bad   = 0;
  int txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: which addresses hit a register, computed with wide integers.
  function automatic bit model_ok(input logic [31:0] a);
    longint la = longint'(a);
    longint lo = longint'(P_OFFSET);
    longint hi = lo + longint'(P_NUM) * longint'(P_STEP);
    if (la < lo || la >= hi) return 1'b0;
    return ((la - lo) % longint'(P_STEP)) == 0;
  endfunction

  // Drives one write; samples on the falling edge, records what it sees.
  task automatic run_txn(input vec_t v, output res_t r);
    int   c = 0;
    int   bv_cnt = 0;
    bit   aw_done = 0, w_done = 0, b_done = 0, resp_seen = 0;
    bit   aw_now, w_now, b_now;
    logic [1:0] first_resp = 2'b00;
    r.we_count = 0; r.we_cycle = -1; r.hs_cycle = -1; r.bv_cycle = -1;
    r.stall = 0; r.viol = 0; r.we_addr = '0; r.we_data = '0; r.we_strb = '0;
    r.resp = 2'b00; r.timeout = 0;
    while (!b_done && c < MAXC) begin
      if (write_en) begin
        r.we_count++;
        r.we_cycle = c;
        r.we_addr  = wr_address;
        r.we_data  = wr_data;
        r.we_strb  = wr_strb;
      end
      if (aw_done && s_awready) r.viol++;
      if (w_done && s_wready) r.viol++;
      if (s_bvalid) begin
        if (!resp_seen) begin
          resp_seen  = 1;
          first_resp = s_bresp;
          r.bv_cycle = c;
        end else if (s_bresp !== first_resp) begin
          r.viol++;
        end
      end else if (resp_seen) begin
        r.viol++;
      end
      s_awaddr  = v.addr;
      s_awvalid = !aw_done && (c >= v.aw_dly);
      s_wdata   = v.data;
      s_wstrb   = v.strb;
      s_wvalid  = !w_done && (c >= v.w_dly);
      s_bready  = (v.b_dly == 0) || (bv_cnt >= v.b_dly);
      if (s_bvalid && !s_bready) begin
        r.stall++;
        if (s_awready || s_wready) r.viol++;
      end
      if (s_bvalid) bv_cnt++;
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      b_now  = s_bvalid && s_bready;
      @(posedge clk);
      if (aw_now) aw_done = 1;
      if (w_now)  w_done  = 1;
      if (aw_done && w_done && r.hs_cycle < 0) r.hs_cycle = c;
      if (b_now) begin
        b_done = 1;
        r.resp = first_resp;
      end
      @(negedge clk);
      c++;
    end
    s_awvalid = 0;
    s_wvalid  = 0;
    s_bready  = 0;
    r.timeout = !b_done;
  endtask

  task automatic check_txn(input vec_t v);
    res_t r;
    int   exp_hs;
    run_txn(v, r);
    exp_hs = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    $display("txn %0d addr=%h data=%h strb=%h we=%0d resp=%0d hs=%0d stall=%0d",
             txn_no, v.addr, v.data, v.strb, r.we_count, r.resp, r.hs_cycle, r.stall);
    txn_no++;
    chk("timeout",   32'(r.timeout), 32'd0);
    chk("we_count",  r.we_count, 32'(v.exp_we));
    if (v.exp_we) begin
      chk("we_addr", r.we_addr, v.addr);
      chk("we_data", r.we_data, v.data);
      chk("we_strb", 32'(r.we_strb), 32'(v.strb));
      chk("we_lat",  r.we_cycle, exp_hs + 1);
    end
    chk("hs_cycle",  r.hs_cycle, exp_hs);
    chk("bv_lat",    r.bv_cycle, exp_hs + 2);
    chk("bresp",     32'(r.resp), 32'(v.exp_resp));
    chk("b_stall",   r.stall, v.b_dly);
    chk("protocol",  r.viol, 0);
    chk("addr_hold", wr_address, v.addr);
    chk("we_idle",   32'(write_en), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(s_awready), 32'd0);
    chk({tag, "_wready"},  32'(s_wready),  32'd0);
    chk({tag, "_bvalid"},  32'(s_bvalid),  32'd0);
    chk({tag, "_bresp"},   32'(s_bresp),   32'd0);
    chk({tag, "_we"},      32'(write_en),  32'd0);
    chk({tag, "_waddr"},   wr_address,     32'd0);
    chk({tag, "_wdata"},   wr_data,        32'd0);
    chk({tag, "_wstrb"},   32'(wr_strb),   32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    int   sel;

    vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 2'b00};
    vecs[1] = '{32'h10, 32'h12345678, 4'hF, 3, 0, 0, 1, 2'b00};
    vecs[2] = '{32'h80, 32'h11111111, 4'hF, 0, 0, 0, 0, 2'b10};
    vecs[3] = '{32'h06, 32'h22222222, 4'h3, 0, 0, 0, 0, 2'b10};
    vecs[4] = '{32'h7C, 32'h33333333, 4'h0, 0, 0, 0, 1, 2'b00};
    vecs[5] = '{32'h00, 32'hA5A5A5A5, 4'h5, 0, 2, 5, 1, 2'b00};
    vecs[6] = '{32'hFFFFFFFC, 32'h44444444, 4'hF, 1, 1, 0, 0, 2'b10};

    rst_n = 0; s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_wvalid = 0; s_bready = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1;
    #1;
    chk("rst_rel_awready", 32'(s_awready), 32'd0);
    chk("rst_rel_wready",  32'(s_wready),  32'd0);
    @(negedge clk);
    chk("post_rst_awready", 32'(s_awready), 32'd1);
    chk("post_rst_wready",  32'(s_wready),  32'd1);

    for (int i = 0; i < 7; i++) check_txn(vecs[i]);

    // Reset after AW is held but before W: the held address must be lost.
    s_awaddr = 32'h04; s_awvalid = 1;
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 0;
    chk("held_awready", 32'(s_awready), 32'd0);
    #2 rst_n = 0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("mid_rel_awready", 32'(s_awready), 32'd0);
    @(negedge clk);
    // W arrives alone first; only the fresh AW six cycles later may complete it.
    v = '{32'h14, 32'hCAFEF00D, 4'hF, 6, 0, 0, 1, 2'b00};
    check_txn(v);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v.addr = 32'($urandom_range(0, 31)) * 32'd4;
        1:       v.addr = 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(1, 3));
        2:       v.addr = $urandom;
        default: v.addr = 32'h7C + 32'($urandom_range(0, 8));
      endcase
      v.data     = $urandom;
      v.strb     = 4'($urandom_range(0, 15));
      v.aw_dly   = int'($urandom_range(0, 3));
      v.w_dly    = int'($urandom_range(0, 3));
      v.b_dly    = int'($urandom_range(0, 3));
      v.exp_we   = model_ok(v.addr);
      v.exp_resp = model_ok(v.addr) ? 2'b00 : 2'b10;
      check_txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_write_slave.md
AXIL_WRITE_SLAVE -- requirements
Module: axil_write_slave

Interface
REQ-001 SHALL have parameter OFFSET, default 0, base byte address of the register window.
REQ-002 SHALL have parameter ADDRESS_STEP, default 4, byte stride between registers.
REQ-003 SHALL have parameter NUM_ADDRESSES, default 32, number of registers in the window.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_awaddr input 32, s_awvalid input 1, s_awready output 1: the AXI4-Lite write-address channel.
REQ-007 SHALL have ports s_wdata input 32, s_wstrb input 4, s_wvalid input 1, s_wready output 1: the AXI4-Lite write-data channel.
REQ-008 SHALL have ports s_bresp output 2, s_bvalid output 1, s_bready input 1: the AXI4-Lite write-response channel.
REQ-009 SHALL have ports wr_address output 32, wr_data output 32, wr_strb output 4, write_en output 1: the write strobe to the downstream address decoder.

Function
REQ-010 SHALL implement states IDLE, WRITE, RESP.
REQ-011 In IDLE: s_awready is high until an AW beat is captured; s_wready is high until a W beat is captured; each channel is captured independently, in either order or in the same cycle.
REQ-012 A captured beat SHALL be held; its ready stays low until the B handshake completes, so a second AW before W (or W before AW) is stalled.
REQ-013 IDLE->WRITE in the cycle after both beats are held; with both handshakes at edge N, write_en is high for exactly the cycle after edge N (edge N+1 samples it).
REQ-014 In WRITE: wr_address, wr_data, wr_strb present the captured values; write_en is asserted only if the address is valid (REQ-016); WRITE->RESP unconditionally after one cycle.
REQ-015 In RESP: s_bvalid is high, s_bresp stable; RESP->IDLE on s_bvalid && s_bready; s_bvalid held indefinitely while s_bready low.
REQ-016 Address is valid iff OFFSET <= addr < OFFSET + NUM_ADDRESSES*ADDRESS_STEP and (addr - OFFSET) % ADDRESS_STEP == 0; comparisons in 33-bit unsigned arithmetic so the window top cannot wrap.
REQ-017 s_bresp SHALL be OKAY (2'b00) for a valid address and SLVERR (2'b10) otherwise; an invalid write never asserts write_en.
REQ-018 wr_address, wr_data, wr_strb SHALL hold their last values outside WRITE; write_en is low outside WRITE.
REQ-019 Minimum throughput: one write per 3 cycles (capture, WRITE, RESP with s_bready high).
REQ-020 s_wstrb SHALL be passed through unmodified; a strobe of 4'b0000 still completes with write_en asserted for a valid address.

Reset
REQ-021 On rst_n low, asynchronously: state IDLE, held-beat flags cleared, s_awready=0, s_wready=0, s_bvalid=0, s_bresp=2'b00, write_en=0, wr_address=0, wr_data=0, wr_strb=0.
REQ-022 s_awready/s_wready SHALL rise no earlier than the first clock edge after rst_n deasserts.
REQ-023 Reset mid-transaction SHALL discard held beats and any pending response; no write_en is produced for the aborted write.

Structure
REQ-024 Package axil_pkg SHALL hold the state enum, the resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, and the data/strobe width constants.
REQ-025 Address validation SHALL be a sub-module axil_addr_check (combinational: address in, valid out, same three parameters).

Verification
REQ-026 AW and W in the same cycle at addr 0x08, data 0xDEADBEEF, bready=1 -> write_en one cycle with wr_address 0x08, wr_data 0xDEADBEEF; bresp OKAY two cycles after the handshake.
REQ-027 W at cycle 0, AW 3 cycles later at 0x10 -> s_wready low after cycle 0; write_en the cycle after AW; bresp OKAY.
REQ-028 addr 0x80 (one past top, defaults) and addr 0x06 (misaligned) -> no write_en; bresp SLVERR for each.
REQ-029 bready held low 5 cycles -> s_bvalid high and bresp stable for all 5; s_awready/s_wready low; second AW is accepted only after the B handshake.
REQ-030 rst_n pulled low after AW captured but before W -> all outputs zero; subsequent W alone produces no write_en; a fresh AW+W completes normally.
